// File: rtl/inst_memaccess_pkg.sv
// inst_memaccess_pkg: shared mem_op encodings, FSM states and byte-mask constants.
package inst_memaccess_pkg;
    localparam logic [2:0] MEMOP_B  = 3'd0;
    localparam logic [2:0] MEMOP_H  = 3'd1;
    localparam logic [2:0] MEMOP_W  = 3'd2;
    localparam logic [2:0] MEMOP_BU = 3'd4;
    localparam logic [2:0] MEMOP_HU = 3'd5;
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
    function automatic logic is_byte(input logic [2:0] op);
        return op == MEMOP_B || op == MEMOP_BU;
    endfunction
    function automatic logic is_half(input logic [2:0] op);
        return op == MEMOP_H || op == MEMOP_HU;
    endfunction
endpackage

// File: rtl/inst_memaccess_mem_lane_align.sv
// inst_memaccess_mem_lane_align: load shift/extend over a two-word window and store byte-lane generation.
module inst_memaccess_mem_lane_align import inst_memaccess_pkg::*; (
    input  logic [2:0]  op,
    input  logic [1:0]  ofs,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [7:0]  be,
    output logic [63:0] wdata
);
    logic [31:0] w;
    assign w = 32'({hi, lo} >> {ofs, 3'b000});
    assign ldata = op == MEMOP_B  ? {{24{w[7]}}, w[7:0]} :
                   op == MEMOP_H  ? {{16{w[15]}}, w[15:0]} :
                   op == MEMOP_BU ? {24'h0, w[7:0]} :
                   op == MEMOP_HU ? {16'h0, w[15:0]} : w;
    // Low nibble addresses the first word, high nibble spills into the next word.
    assign be = (is_byte(op) ? MASK_B : is_half(op) ? MASK_H : MASK_W) << ofs;
    assign wdata = {32'h0, sdata} << {ofs, 3'b000};
endmodule

// File: rtl/inst_memaccess.sv
// inst_memaccess: memory-access stage with two-cycle misaligned split; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead.
module inst_memaccess import inst_memaccess_pkg::*; #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex2mem_mem_en,
    input  logic          ex2mem_load,
    input  logic          ex2mem_store,
    input  logic [2:0]    ex2mem_mem_op,
    input  logic [AW-1:0] ex2mem_memaddr,
    input  logic [DW-1:0] ex2mem_wr_memwdata,
    input  logic          ex2mem_wr_reg,
    input  logic [4:0]    ex2mem_wr_regindex,
    input  logic [DW-1:0] ex2mem_wr_wdata,
    input  logic          ex2mem_exp,
    input  logic [DW-1:0] readram_rdata,
    input  logic [DW-1:0] memram_rdata,
    output logic          memram_en,
    output logic          memram_we,
    output logic [AW-1:0] memram_addr,
    output logic [3:0]    memram_be,
    output logic [DW-1:0] memram_wdata,
    output logic          mem_misaligned_exxeption,
    output logic [AW-1:0] mem2ex_memadr,
    output logic [2:0]    mem2ex_mem_op,
    output logic          mem2wb_wr_reg,
    output logic [4:0]    mem2wb_wr_regindex,
    output logic [DW-1:0] mem2wb_wr_wdata,
    output logic          mem2wb_exp
);
    state_t state, state_n;
    logic [DW-1:0] lo_q, sdata_q, ldata;
    logic [1:0] ofs, ofs_q;
    logic st_q, wr_reg_q, split, is_load, is_store, mis, trap, go_split, wr_ok, rd_nxt;
    logic [4:0] idx_q;
    logic [7:0] be;
    logic [63:0] wdata;
    logic [AW-1:0] word_addr, nxt_addr;
    assign split = state == SPLIT;
    assign is_load = ex2mem_load;
    assign is_store = ex2mem_store & ~ex2mem_load;
    assign ofs = ex2mem_memaddr[1:0];
    assign mis = (is_half(ex2mem_mem_op) && ofs == 2'd3) || (ex2mem_mem_op == MEMOP_W && ofs != 2'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ex2mem_mem_en & mis;
`else
    assign trap = 1'b0;
`endif
    assign go_split = !split && ex2mem_mem_en && mis && !ex2mem_exp && !trap;
    assign wr_ok = !split && ex2mem_mem_en && is_store && !ex2mem_exp && !trap;
    assign rd_nxt = go_split && is_load;
    assign word_addr = {ex2mem_memaddr[AW-1:2], 2'b00};
    assign nxt_addr = word_addr + AW'(4);
    // One aligner serves both paths: live inputs in IDLE, latched split context in SPLIT.
    inst_memaccess_mem_lane_align u_mem_lane_align (
        .op    (split ? mem2ex_mem_op : ex2mem_mem_op),
        .ofs   (split ? ofs_q : ofs),
        .lo    (split ? lo_q : readram_rdata),
        .hi    (memram_rdata),
        .sdata (split ? sdata_q : ex2mem_wr_memwdata),
        .ldata (ldata),
        .be    (be),
        .wdata (wdata)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb state_n = split ? IDLE : go_split ? SPLIT : IDLE;
    always_comb begin
        mem_misaligned_exxeption = split;
        memram_en = !reset && (split ? st_q : (wr_ok || rd_nxt));
        memram_we = !reset && (split ? st_q : wr_ok);
        memram_addr = !memram_en ? '0 : split ? mem2ex_memadr : rd_nxt ? nxt_addr : word_addr;
        memram_be = !memram_we ? 4'h0 : split ? be[7:4] : be[3:0];
        memram_wdata = !memram_we ? '0 : split ? wdata[63:32] : wdata[31:0];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lo_q <= '0;
            sdata_q <= '0;
            ofs_q <= '0;
            st_q <= 1'b0;
            wr_reg_q <= 1'b0;
            idx_q <= '0;
            mem2ex_memadr <= '0;
            mem2ex_mem_op <= '0;
            mem2wb_wr_reg <= 1'b0;
            mem2wb_wr_regindex <= '0;
            mem2wb_wr_wdata <= '0;
            mem2wb_exp <= 1'b0;
        end else begin
            if (go_split) begin
                lo_q <= readram_rdata;
                sdata_q <= ex2mem_wr_memwdata;
                ofs_q <= ofs;
                st_q <= is_store;
                wr_reg_q <= ex2mem_wr_reg;
                idx_q <= ex2mem_wr_regindex;
                mem2ex_memadr <= nxt_addr;
                mem2ex_mem_op <= ex2mem_mem_op;
            end
            if (split) begin
                mem2wb_wr_reg <= !st_q && wr_reg_q;
                mem2wb_wr_regindex <= idx_q;
                mem2wb_wr_wdata <= ldata;
                mem2wb_exp <= 1'b0;
            end else begin
                mem2wb_wr_reg <= ex2mem_wr_reg && !ex2mem_exp && !trap && !go_split && !(ex2mem_mem_en && is_store);
                mem2wb_wr_regindex <= ex2mem_wr_regindex;
                mem2wb_wr_wdata <= (ex2mem_mem_en && is_load) ? ldata : ex2mem_wr_wdata;
                mem2wb_exp <= ex2mem_exp || trap;
            end
        end
endmodule

// File: tb/tb_inst_memaccess.sv
// tb_inst_memaccess: byte-memory reference model with directed and random load/store traffic.
module tb_inst_memaccess;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    logic ex2mem_mem_en, ex2mem_load, ex2mem_store, ex2mem_wr_reg, ex2mem_exp;
    logic [2:0] ex2mem_mem_op;
    logic [31:0] ex2mem_memaddr, ex2mem_wr_memwdata, ex2mem_wr_wdata, readram_rdata, memram_rdata;
    logic [4:0] ex2mem_wr_regindex;
    logic memram_en, memram_we, mem_misaligned_exxeption, mem2wb_wr_reg, mem2wb_exp;
    logic [31:0] memram_addr, memram_wdata, mem2ex_memadr, mem2wb_wr_wdata;
    logic [3:0] memram_be;
    logic [2:0] mem2ex_mem_op;
    logic [4:0] mem2wb_wr_regindex;
    int tests = 0;
    int fails = 0;
    logic [7:0] mem8 [256];
    logic [7:0] ref8 [256];
    logic poke_en = 1'b0;
    logic [31:0] poke_addr = '0, poke_data = '0;
    logic e_split, e_wr, e_exp;
    logic [31:0] e_data, e_nxt;
    logic [4:0] e_idx;
    logic [2:0] e_op;
    logic [2:0] lops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always #5 clk = ~clk;

    inst_memaccess dut (
        .clk(clk), .reset(reset),
        .ex2mem_mem_en(ex2mem_mem_en), .ex2mem_load(ex2mem_load), .ex2mem_store(ex2mem_store),
        .ex2mem_mem_op(ex2mem_mem_op), .ex2mem_memaddr(ex2mem_memaddr), .ex2mem_wr_memwdata(ex2mem_wr_memwdata),
        .ex2mem_wr_reg(ex2mem_wr_reg), .ex2mem_wr_regindex(ex2mem_wr_regindex), .ex2mem_wr_wdata(ex2mem_wr_wdata),
        .ex2mem_exp(ex2mem_exp), .readram_rdata(readram_rdata), .memram_rdata(memram_rdata),
        .memram_en(memram_en), .memram_we(memram_we), .memram_addr(memram_addr), .memram_be(memram_be),
        .memram_wdata(memram_wdata), .mem_misaligned_exxeption(mem_misaligned_exxeption),
        .mem2ex_memadr(mem2ex_memadr), .mem2ex_mem_op(mem2ex_mem_op), .mem2wb_wr_reg(mem2wb_wr_reg),
        .mem2wb_wr_regindex(mem2wb_wr_regindex), .mem2wb_wr_wdata(mem2wb_wr_wdata), .mem2wb_exp(mem2wb_exp)
    );

    function automatic logic [31:0] word(input logic [31:0] ad);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem8[8'({ad[31:2], 2'b00} + 32'(i))];
        return w;
    endfunction

    // Byte-addressed RAM (aliased modulo 256) with a one-cycle read port.
    always @(posedge clk) begin
        if (poke_en)
            for (int i = 0; i < 4; i++) mem8[8'(poke_addr + 32'(i))] <= poke_data[8*i +: 8];
        if (memram_en && memram_we)
            for (int i = 0; i < 4; i++) if (memram_be[i]) mem8[8'(memram_addr + 32'(i))] <= memram_wdata[8*i +: 8];
        if (memram_en && !memram_we) memram_rdata <= word(memram_addr);
    end

    function automatic int size_of(input logic [2:0] op);
        return (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] ad);
        logic [31:0] v = '0;
        for (int i = 0; i < size_of(op); i++) v[8*i +: 8] = ref8[8'(ad + 32'(i))];
        if (op == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (op == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 256; i++) if (mem8[i] !== ref8[i]) d++;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] ad, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_addr = ad;
        poke_data = d;
        for (int i = 0; i < 4; i++) ref8[8'(ad + 32'(i))] = d[8*i +: 8];
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic idle_inputs();
        ex2mem_mem_en = 0; ex2mem_load = 0; ex2mem_store = 0; ex2mem_mem_op = 0;
        ex2mem_memaddr = 0; ex2mem_wr_memwdata = 0; ex2mem_wr_reg = 0; ex2mem_wr_regindex = 0;
        ex2mem_wr_wdata = 0; ex2mem_exp = 0; readram_rdata = 0;
    endtask

    task automatic drive_op(input bit en, input bit ld, input bit st, input logic [2:0] op,
                            input logic [31:0] ad, input logic [31:0] sd, input bit wr,
                            input logic [4:0] idx, input logic [31:0] wd, input bit ex, input bit partial);
        bit mis, st_eff;
        @(negedge clk);
        ex2mem_mem_en = en; ex2mem_load = ld; ex2mem_store = st; ex2mem_mem_op = op;
        ex2mem_memaddr = ad; ex2mem_wr_memwdata = sd; ex2mem_wr_reg = wr; ex2mem_wr_regindex = idx;
        ex2mem_wr_wdata = wd; ex2mem_exp = ex; readram_rdata = word(ad);
        // Misaligned means the access crosses a word boundary.
        mis = en && (ld || st) && (int'(ad[1:0]) + size_of(op) > 4);
        st_eff = st && !ld;
        e_split = mis && !ex && !TRAP;
        e_exp = ex || (mis && TRAP);
        e_wr = wr && !e_exp && !(en && st_eff);
        e_data = (en && ld) ? ref_load(op, ad) : wd;
        e_idx = idx;
        e_op = op;
        e_nxt = {ad[31:2], 2'b00} + 32'd4;
        if (en && st_eff && !e_exp)
            for (int i = 0; i < size_of(op); i++)
                if (!partial || ((ad + 32'(i)) >> 2) == (ad >> 2)) ref8[8'(ad + 32'(i))] = sd[8*i +: 8];
    endtask

    task automatic finish_op(input bit first_done);
        if (!first_done) begin @(posedge clk); #1; end
        chk("split_flag", 32'(mem_misaligned_exxeption), 32'(e_split));
        if (e_split) begin
            chk("next_adr", mem2ex_memadr, e_nxt);
            chk("split_op", 32'(mem2ex_mem_op), 32'(e_op));
            chk("bubble", 32'(mem2wb_wr_reg), 32'd0);
            @(posedge clk); #1;
            chk("split_done", 32'(mem_misaligned_exxeption), 32'd0);
        end
        chk("wb_reg", 32'(mem2wb_wr_reg), 32'(e_wr));
        chk("wb_exp", 32'(mem2wb_exp), 32'(e_exp));
        if (e_wr) begin
            chk("wb_data", mem2wb_wr_wdata, e_data);
            chk("wb_idx", 32'(mem2wb_wr_regindex), 32'(e_idx));
        end
        idle_inputs();
        chk("mem", 32'(mem_diffs()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(memram_en), 0);
        chk({tag, "_we"}, 32'(memram_we), 0);
        chk({tag, "_addr"}, memram_addr, 0);
        chk({tag, "_be"}, 32'(memram_be), 0);
        chk({tag, "_wdata"}, memram_wdata, 0);
        chk({tag, "_exc"}, 32'(mem_misaligned_exxeption), 0);
        chk({tag, "_madr"}, mem2ex_memadr, 0);
        chk({tag, "_mop"}, 32'(mem2ex_mem_op), 0);
        chk({tag, "_wbreg"}, 32'(mem2wb_wr_reg), 0);
        chk({tag, "_wbidx"}, 32'(mem2wb_wr_regindex), 0);
        chk({tag, "_wbdata"}, mem2wb_wr_wdata, 0);
        chk({tag, "_wbexp"}, 32'(mem2wb_exp), 0);
    endtask

    initial begin
        bit en, ld, st, ex, wr;
        int sel;
        logic [2:0] op;
        reset = 1'b1;
        idle_inputs();
        #1 chk_all_zero("reset");
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 64; i++) poke(32'(4 * i), $urandom());

        poke(32'h100, 32'hDEADBEEF);
        drive_op(1, 1, 0, 3'd2, 32'h100, 0, 1, 5'd5, 32'h0, 0, 0);
        finish_op(0);
        chk("lw_const", mem2wb_wr_wdata, 32'hDEADBEEF);

        poke(32'h100, 32'h80112233);
        drive_op(1, 1, 0, 3'd0, 32'h103, 0, 1, 5'd6, 32'h0, 0, 0);
        finish_op(0);
        chk("lb_const", mem2wb_wr_wdata, 32'hFFFFFF80);
        drive_op(1, 1, 0, 3'd4, 32'h103, 0, 1, 5'd7, 32'h0, 0, 0);
        finish_op(0);
        chk("lbu_const", mem2wb_wr_wdata, 32'h00000080);

        drive_op(1, 0, 1, 3'd1, 32'h102, 32'h0000ABCD, 1, 5'd8, 32'h0, 0, 0);
        #1;
        chk("sh_we", 32'(memram_we), 1);
        chk("sh_be", 32'(memram_be), 32'hC);
        chk("sh_wdata", memram_wdata, 32'hABCD0000);
        chk("sh_addr", memram_addr, 32'h100);
        finish_op(0);

        poke(32'h1FC, 32'h3344AAAA);
        poke(32'h200, 32'hBBBB1122);
        drive_op(1, 1, 0, 3'd2, 32'h1FE, 0, 1, 5'd9, 32'h0, 0, 0);
        #1;
        chk("lwm_rd_en", 32'(memram_en), 1);
        chk("lwm_rd_we", 32'(memram_we), 0);
        chk("lwm_rd_addr", memram_addr, 32'h200);
        finish_op(0);
        chk("lwm_const", mem2wb_wr_wdata, TRAP ? 32'h0 : 32'h11223344);

        drive_op(1, 0, 1, 3'd2, 32'hFFFFFFFF, 32'h11223344, 0, 5'd0, 32'h0, 0, 0);
        #1;
        chk("swm1_be", 32'(memram_be), TRAP ? 32'h0 : 32'h8);
        chk("swm1_wdata", memram_wdata, TRAP ? 32'h0 : 32'h44000000);
        chk("swm1_addr", memram_addr, TRAP ? 32'h0 : 32'hFFFFFFFC);
        @(posedge clk); #1;
        chk("swm2_be", 32'(memram_be), TRAP ? 32'h0 : 32'h7);
        chk("swm2_wdata", memram_wdata, TRAP ? 32'h0 : 32'h00112233);
        chk("swm2_addr", memram_addr, 32'h0);
        finish_op(1);

        drive_op(1, 0, 1, 3'd2, 32'h00000042, 32'hCAFEF00D, 1, 5'd3, 32'h0, 0, 1);
        @(posedge clk); #1;
        chk("rst_split", 32'(mem_misaligned_exxeption), TRAP ? 32'd0 : 32'd1);
        #1 reset = 1'b1;
        #1 chk_all_zero("rst_mid");
        idle_inputs();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem", 32'(mem_diffs()), 0);
        chk("rst_state", 32'(mem_misaligned_exxeption), 0);

        drive_op(1, 0, 1, 3'd2, 32'h00000080, 32'h12345678, 1, 5'd4, 32'h0, 1, 0);
        finish_op(0);

        for (int k = 0; k < 300; k++) begin
            en = $urandom_range(0, 9) < 8;
            sel = $urandom_range(0, 2);
            ld = en && sel != 1;
            st = en && sel != 0;
            op = (st && !ld) ? 3'($urandom_range(0, 2)) : lops[$urandom_range(0, 4)];
            ex = $urandom_range(0, 9) == 0;
            wr = $urandom_range(0, 3) != 0;
            drive_op(en, ld, st, op, $urandom(), $urandom(), wr, 5'($urandom()), $urandom(), ex, 0);
            finish_op(0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_memaccess.md
Name: inst_memaccess

Overview:
- Memory-access stage of the pipeline. Consumes the ex2mem_* bundle from the execute stage.
- Performs load data extraction and sign/zero extension, and store byte-lane generation.
- Drives the data-RAM write/second-read port and registers results toward writeback.
- Detects misaligned accesses and splits them into two aligned word accesses. During the split it drives the mem2ex_* feedback (exception flag, next address, op) that holds and redirects the execute stage.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; fixed at 32.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- ex2mem_mem_en  in  1  memory access valid this cycle.
- ex2mem_load  in  1  access is a load.
- ex2mem_store  in  1  access is a store.
- ex2mem_mem_op  in  3  funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- ex2mem_memaddr  in  AW  byte address.
- ex2mem_wr_memwdata  in  32  store data, right-aligned.
- ex2mem_wr_reg  in  1  register write enable.
- ex2mem_wr_regindex  in  5  destination register.
- ex2mem_wr_wdata  in  32  ALU result, used when not a load.
- ex2mem_exp  in  1  upstream exception.
- readram_rdata  in  32  first load word, from the read issued by execute in the previous cycle.
- memram_rdata  in  32  second-word read data, one cycle after memram_en.
- memram_en  out  1  data-RAM port access.
- memram_we  out  1  write.
- memram_addr  out  AW  word-aligned address.
- memram_be  out  4  byte enables.
- memram_wdata  out  32  lane-aligned write data.
- mem_misaligned_exxeption  out  1  split in progress; execute/decode hold.
- mem2ex_memadr  out  AW  address of second word.
- mem2ex_mem_op  out  3  latched op of the split access.
- mem2wb_wr_reg  out  1  registered write enable.
- mem2wb_wr_regindex  out  5  registered destination.
- mem2wb_wr_wdata  out  32  registered result.
- mem2wb_exp  out  1  registered exception.

Behaviour:
- Reset: asynchronous. State=IDLE; all mem2wb_* = 0; memram_* = 0; mem_misaligned_exxeption=0; mem2ex_memadr=0; mem2ex_mem_op=0.
- a = ex2mem_memaddr[1:0]. Misaligned when (op H/HU and a==3) or (op W and a!=0). B/BU is never misaligned.
- Aligned path (IDLE, non-misaligned), latency 1:
  - Load: result = (readram_rdata >> 8*a), truncated per op; sign-extended for B/H, zero-extended for BU/HU.
  - Non-memory op: result = ex2mem_wr_wdata.
  - mem2wb_* registered at the next edge.
  - Store: combinationally memram_en=1, memram_we=1, addr=memaddr&~3, be=(1/3/F)<<a, wdata=memwdata<<8*a. mem2wb_wr_reg forced 0.
- FSM states: IDLE, SPLIT.
  - IDLE -> SPLIT on mem_en & misaligned & !ex2mem_exp.
    - Latch low word (readram_rdata), addr, op, and store data; set mem_misaligned_exxeption=1.
    - Set mem2ex_memadr = (addr&~3)+4, wrapping modulo 2^AW; set mem2ex_mem_op=op.
    - Store: first-word write with be = lowmask[3:0], where the 8-bit lowmask = (3/F)<<a.
    - Load: memram_en=1, we=0, addr=mem2ex_memadr.
    - mem2wb_wr_reg=0 this edge (bubble).
  - SPLIT -> IDLE after one cycle.
    - Load: result = ({memram_rdata, low_word} >> 8*a)[width], then extended. Registered to mem2wb.
    - Store: memram_en=1, we=1, addr=mem2ex_memadr, be=lowmask[7:4], wdata=(store<<8*a)[63:32].
    - mem_misaligned_exxeption deasserts with the transition.
- Upstream holds ex2mem_* stable while mem_misaligned_exxeption=1. Inputs are ignored in SPLIT.
- ex2mem_exp=1: no RAM write, no split. mem2wb_exp=1 and mem2wb_wr_reg=0 next cycle.
- Reset asserted in SPLIT: returns to IDLE immediately, second write is dropped, and no partial writeback occurs.
- Both load and store asserted: treated as load.

Optional Feature:
- MEM_MISALIGN_TRAP_EN.
- Defined: misaligned access never enters SPLIT. No RAM write; mem2wb_exp=1, mem2wb_wr_reg=0 next cycle; mem_misaligned_exxeption tied 0.
- Undefined: hardware split as above.

Decomposition:
- Shared package/header: mem_op encodings (MEMOP_B/H/W/BU/HU), FSM state constants, byte-mask constants.
- One natural sub-module, mem_lane_align: combinational shift/extend for loads and be/wdata generation for stores. Instantiated for the aligned and split paths.

Test Plan:
- LW addr 0x100, readram_rdata=0xDEADBEEF -> next cycle mem2wb_wr_wdata=0xDEADBEEF, wr_reg=1; no split.
- LB addr 0x103, rdata=0x80112233 -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102 data 0x0000ABCD -> memram_be=0xC, wdata=0xABCD0000, addr=0x100, we=1.
- LW addr 0x1FE, low word 0x3344AAAA, memram_rdata=0xBBBB1122:
  - exception high 1 cycle, mem2ex_memadr=0x200, memram read 0x200.
  - Result 0x11223344.
- SW addr 0xFFFFFFFF data 0x11223344 -> cycle1 be=0x8, wdata=0x44000000 @0xFFFFFFFC; cycle2 be=0x7, wdata=0x00112233 @0x00000000 (wrap).
- Reset asserted mid-SPLIT store -> no second write; all outputs 0; state IDLE.
- With MEM_MISALIGN_TRAP_EN: LW at 0x1FE -> mem2wb_exp=1, no memram_we.
